// File: rtl/rr_arbiter_n_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The arbiter takes the slave side; requesters or a bench take the master side.
interface rr_arbiter_n_if #(
    parameter int W_REQ = 8
);
    localparam int IDX_W = $clog2(W_REQ);

    logic [W_REQ-1:0] req;
    logic             done;
    logic [W_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             preempt;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  preempt
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output grant_valid,
        output preempt
    );
endinterface

// File: rtl/rr_arbiter_n.sv
// Registered round-robin arbiter with grant hold and zero-bubble handover.
// Define RR_ARB_HOLD_TIMEOUT_EN to add MAX_HOLD-cycle preemption of a holder.
module rr_arbiter_n #(
    parameter int W_REQ    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter_n_if.slave bus
);

    localparam int               IDX_W    = $clog2(W_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W_REQ - 1);
    localparam logic [W_REQ-1:0] ONE_HOT0 = W_REQ'(1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state_q, state_d;
    logic [W_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] pick;
    logic             new_grant;
    logic             release_now;

    // Masked LSB-first search: lowest set bit at or above p wins, else lowest set bit overall.
    function automatic logic [IDX_W-1:0] win(input logic [W_REQ-1:0] v,
                                             input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] hi;
        logic [IDX_W-1:0] lo;
        logic             hi_found;
        hi       = '0;
        lo       = '0;
        hi_found = 1'b0;
        for (int i = W_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                lo = IDX_W'(i);
                if (i >= int'(p)) begin
                    hi       = IDX_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        return hi_found ? hi : lo;
    endfunction

    assign release_now = bus.done | ~bus.req[idx_q];

`ifdef RR_ARB_HOLD_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    // Counts cycles the current holder has been granted, including the current one.
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              preempt_q, preempt_d;
    logic              expire;

    assign expire = (hold_q >= HOLD_W'(MAX_HOLD)) && (|(bus.req & ~grant_q));
`else
    logic unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        pick      = '0;
        new_grant = 1'b0;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        preempt_d = 1'b0;
        hold_d    = hold_q;
        if ((state_q == GRANT) && (hold_q < HOLD_W'(MAX_HOLD))) begin
            hold_d = hold_q + 1'b1;
        end
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    new_grant = 1'b1;
                    pick      = win(bus.req, ptr_q);
                end
            end
            GRANT: begin
                if (release_now) begin
                    if (|bus.req) begin
                        new_grant = 1'b1;
                        pick      = win(bus.req, ptr_q);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
`ifdef RR_ARB_HOLD_TIMEOUT_EN
                else if (expire) begin
                    new_grant = 1'b1;
                    pick      = win(bus.req & ~grant_q, ptr_q);
                    preempt_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // Every new winner drops to lowest priority by moving the pointer just past it.
        if (new_grant) begin
            state_d = GRANT;
            grant_d = ONE_HOT0 << pick;
            idx_d   = pick;
            ptr_d   = (pick == LAST_IDX) ? '0 : pick + 1'b1;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            hold_d  = HOLD_W'(1);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef RR_ARB_HOLD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.preempt = preempt_q;
`else
    assign bus.preempt = 1'b0;
`endif

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = |grant_q;

endmodule
